bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble).
- Generalises the single-digit hundreds extractor to any input width and digit count, with a start/busy/done handshake and overflow detection.
- Feeds the decimal display path of the cpu15 design. Conversion runs one input bit per clock, so area stays small for wide inputs.

---
 rtl/bin_to_bcd_seq.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per clock)
//   CLK      rising-edge system clock
//   RESET    synchronous active-high reset, has priority over START
//   START    request conversion of BIN_IN; only honoured in IDLE or FINISH
//   BIN_IN   unsigned binary operand, captured on the accepting edge
//   BUSY     high while converting (BIN_W cycles)
//   DONE     one-cycle pulse when BCD_OUT/OVERFLOW have just been updated
//   BCD_OUT  packed BCD result, digit 0 in [3:0], held until the next completion
//   OVERFLOW result needed more than DIGITS digits; BCD_OUT then holds the low digits
module bin_to_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD_OUT,
    output logic                  OVERFLOW
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CONV   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;
    localparam logic [CW-1:0] CNT_INIT = CW'(BIN_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [BW-1:0]    bcd_out_q, bcd_out_d;
    logic             overflow_q, overflow_d;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    bcd_sh;
    logic [BIN_W-1:0] bin_sh;
    logic             ovf_sh;
    logic             accept;
    logic             last;

    // add-3 correction on every digit that would reach >=10 after doubling
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    // a bit leaving the top digit means the value no longer fits in DIGITS digits;
    // the lower digits are unaffected, so they still give the value mod 10^DIGITS
    assign bcd_sh = {adj[BW-2:0], bin_sr_q[BIN_W-1]};
    assign bin_sh = bin_sr_q << 1;
    assign ovf_sh = ovf_q | adj[BW-1];
    assign accept = START && (state_q == IDLE || state_q == FINISH);
    assign last   = (cnt_q == CNT_ONE);

    always_comb begin
        state_d    = state_q;
        bin_sr_d   = bin_sr_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;
        if (state_q == CONV) begin
            bin_sr_d = bin_sh;
            bcd_d    = bcd_sh;
            ovf_d    = ovf_sh;
            cnt_d    = cnt_q - CNT_ONE;
            if (last) begin
                bcd_out_d  = bcd_sh;
                overflow_d = ovf_sh;
                state_d    = FINISH;
            end
        end else if (accept) begin
            bin_sr_d = BIN_IN;
            bcd_d    = '0;
            ovf_d    = 1'b0;
            cnt_d    = CNT_INIT;
            state_d  = CONV;
        end else begin
            state_d  = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            bin_sr_q   <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_sr_q   <= bin_sr_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign BUSY     = (state_q == CONV);
    assign DONE     = (state_q == FINISH);
    assign BCD_OUT  = bcd_out_q;
    assign OVERFLOW = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: checks bin_to_bcd_seq (4-digit and 2-digit builds) against a decimal model
module tb_bin_to_bcd_seq;
    localparam int BIN_W = 10;

    logic             CLK;
    logic             RESET;
    logic             START;
    logic [BIN_W-1:0] BIN_IN;
    logic             BUSY, DONE, OVERFLOW;
    logic [15:0]      BCD_OUT;
    logic             BUSY2, DONE2, OVERFLOW2;
    logic [7:0]       BCD_OUT2;

    int total = 0;
    int bad   = 0;
    logic [15:0] prev4;
    logic [7:0]  prev2;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) u_dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BIN_IN(BIN_IN),
        .BUSY(BUSY), .DONE(DONE), .BCD_OUT(BCD_OUT), .OVERFLOW(OVERFLOW)
    );

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .START(START), .BIN_IN(BIN_IN),
        .BUSY(BUSY2), .DONE(DONE2), .BCD_OUT(BCD_OUT2), .OVERFLOW(OVERFLOW2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int v, input int d);
        logic [15:0] r = '0;
        int x = v % (10 ** d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            check("busy_done4", {31'b0, BUSY & DONE}, 32'd0);
            check("busy_done2", {31'b0, BUSY2 & DONE2}, 32'd0);
        end
    end

    task automatic wait_done();
        int n = 0;
        while (BUSY && n < 64) begin
            n++;
            cycle();
        end
        check("busy_len", n, BIN_W);
    endtask

    task automatic expect_result(input int v);
        logic [15:0] e4 = bcd_of(v, 4);
        logic [15:0] e2 = bcd_of(v, 2);
        check("done4", {31'b0, DONE}, 32'd1);
        check("done2", {31'b0, DONE2}, 32'd1);
        check("bcd4", {16'b0, BCD_OUT}, {16'b0, e4});
        check("ovf4", {31'b0, OVERFLOW}, {31'b0, v >= 10000});
        check("bcd2", {24'b0, BCD_OUT2}, {24'b0, e2[7:0]});
        check("ovf2", {31'b0, OVERFLOW2}, {31'b0, v >= 100});
        prev4 = e4;
        prev2 = e2[7:0];
    endtask

    task automatic convert(input int v);
        START  = 1'b1;
        BIN_IN = BIN_W'(v);
        cycle();
        START  = 1'b0;
        BIN_IN = BIN_W'($urandom);
        check("hold4", {16'b0, BCD_OUT}, {16'b0, prev4});
        check("hold2", {24'b0, BCD_OUT2}, {24'b0, prev2});
        wait_done();
        expect_result(v);
        cycle();
        check("pulse", {31'b0, DONE}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET  = 1'b1;
        START  = 1'b1;
        BIN_IN = 10'd77;
        prev4  = '0;
        prev2  = '0;
        cycle();
        cycle();
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_done", {31'b0, DONE}, 32'd0);
        check("rst_bcd", {16'b0, BCD_OUT}, 32'd0);
        check("rst_ovf", {31'b0, OVERFLOW}, 32'd0);
        START = 1'b0;
        RESET = 1'b0;
        cycle();
        check("idle_busy", {31'b0, BUSY}, 32'd0);

        convert(0);
        convert(999);
        convert(1023);
        convert(345);
        convert(99);

        // back-to-back with START held; BIN_IN change mid-conversion must not matter
        START  = 1'b1;
        BIN_IN = 10'd255;
        cycle();
        BIN_IN = 10'd7;
        wait_done();
        expect_result(255);
        cycle();
        check("b2b_busy", {31'b0, BUSY}, 32'd1);
        START = 1'b0;
        wait_done();
        expect_result(7);
        cycle();
        check("b2b_idle", {31'b0, DONE | BUSY}, 32'd0);

        // abort in the 5th busy cycle
        convert(512);
        START  = 1'b1;
        BIN_IN = 10'd300;
        cycle();
        START = 1'b0;
        repeat (4) cycle();
        check("abort_busy_pre", {31'b0, BUSY}, 32'd1);
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        check("abort_busy", {31'b0, BUSY}, 32'd0);
        check("abort_done", {31'b0, DONE}, 32'd0);
        check("abort_bcd", {16'b0, BCD_OUT}, 32'd0);
        check("abort_ovf", {31'b0, OVERFLOW}, 32'd0);
        prev4 = '0;
        prev2 = '0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("abort_quiet", {31'b0, DONE | BUSY}, 32'd0);
        end
        convert(42);

        for (int i = 0; i < 200; i++) begin
            convert(int'($urandom_range(0, 1023)));
            repeat ($urandom_range(0, 2)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
